mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the basic processor's single-master memory bus. It answers the sequencer's `CS`/`R_NW` access strobes using the address held in MAR and the write data held in MDR. It stores words in an internal array and returns read data on a registered output that MDR loads in the following cycle. A side-band program-load port fills the array before or between runs. An optional wait-state count supports slower memory models, signalled on `ready`.

## Interface
- `WORD_W`, 8, data word width.
- `ADDR_W`, 5, address width; array depth is 2**ADDR_W words.
- `WAIT_STATES`, 0, extra cycles between access acceptance and array access (0–15).

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `CS`  in  1  access strobe from sequencer; sampled on rising edge.
- `R_NW`  in  1  1 = read, 0 = write; qualified by `CS`.
- `addr`  in  ADDR_W  access address (MAR contents).
- `wdata`  in  WORD_W  write data (MDR contents).
- `rdata`  out  WORD_W  registered read data, held until next read completes.
- `rdata_valid`  out  1  one-cycle pulse: `rdata` updated this cycle.
- `ready`  out  1  high when IDLE and able to accept `CS` or a program write.
- `collision`  out  1  sticky error flag, cleared only by `reset`.
- `prog_we`  in  1  program-load write enable.
- `prog_addr`  in  ADDR_W  program-load address.
- `prog_data`  in  WORD_W  program-load data.

## Operation
- Reset values: `rdata`=0, `rdata_valid`=0, `ready`=1, `collision`=0, state IDLE, wait counter 0. The memory array is not cleared by reset.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE with `CS`=1:
  - Capture `addr`, `R_NW` and `wdata` into internal registers.
  - If WAIT_STATES=0, perform the access on this same edge and remain in IDLE.
  - Otherwise load the counter with WAIT_STATES−1 and go to WAIT.
- WAIT: decrement the counter each cycle. At 0, go to ACCESS.
- ACCESS: perform the access using the captured values, then go to IDLE.
- Read access: `rdata` <= mem[captured addr], and `rdata_valid` is high for exactly the next cycle.
- Write access: mem[captured addr] <= captured wdata. `rdata` is unchanged and no `rdata_valid` pulse is generated.
- `CS` in WAIT or ACCESS: ignored and `collision` set. The access in flight completes using its originally captured values.
- Program write:
  - In IDLE with `CS`=0, `prog_we`=1 writes mem[`prog_addr`] <= `prog_data` on the edge.
  - `prog_we` with `CS`=1 in the same cycle: `CS` wins, the program write is dropped, and `collision` is set.
  - `prog_we` outside IDLE: dropped and `collision` set.
- Address wrap: none needed. The address is exactly ADDR_W bits and all values are valid.
- `reset` mid-access: the FSM returns to IDLE immediately. A pending write is discarded and the array is untouched. Outputs take their reset values.

## Timing
- WAIT_STATES=0:
  - `CS` high in cycle n (sequencer fetch or operand-read state).
  - Read: `rdata` is valid and `rdata_valid`=1 in cycle n+1, when the sequencer asserts `MDR_bus`.
  - Write: array updated at the end of cycle n. A read in cycle n+1 returns the new data.
- WAIT_STATES=W>0:
  - `CS` accepted at the end of cycle n. WAIT occupies cycles n+1..n+W, and ACCESS is cycle n+W+1.
  - Read data and `rdata_valid` appear in cycle n+W+2.
  - `ready` is low in cycles n+1..n+W+1.
- `ready` is combinational from state only (IDLE → 1) and has no path from `CS`.
- `collision` rises the cycle after the offending edge and stays high until `reset`.

## Test plan
- WAIT_STATES=0:
  - Program-load mem[3]=0x5A, then `CS`=1, `R_NW`=1, `addr`=3.
  - Required: `rdata`=0x5A and `rdata_valid`=1 for exactly one cycle, next cycle.
- Write then read:
  - `CS`=1, `R_NW`=0, `addr`=7, `wdata`=0xC3, followed next cycle by a read of addr 7.
  - Required: `rdata`=0xC3. No `rdata_valid` pulse on the write.
- WAIT_STATES=2, read addr 0 (preloaded 0x11):
  - Required: `ready` low for 3 cycles, and `rdata`=0x11 with `rdata_valid` 4 cycles after `CS`.
  - A second `CS` during WAIT sets `collision`=1, and `rdata` is still 0x11.
- Simultaneous `CS` write (addr 4, 0x22) and `prog_we` (addr 4, 0x99):
  - Required: mem[4]=0x22 and `collision`=1.
- WAIT_STATES=3, write to addr 9 (old value 0x01) with `reset` pulsed during WAIT:
  - Required: mem[9] still 0x01 on readback, `ready`=1, and `rdata`=0 immediately after reset.
- Full sweep:
  - Program-load mem[i]=i^0xA5 for all 32 addresses, then read each back.
  - Required: every read matches, including addr 31 and addr 0.

Source files
------------

// File: rtl/mem_responder_if.sv
// Memory bus between the sequencer (master) and the memory responder (slave),
// including the side-band program-load port.
interface mem_responder_if #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned ADDR_W = 5
);
   logic              CS;
   logic              R_NW;
   logic [ADDR_W-1:0] addr;
   logic [WORD_W-1:0] wdata;
   logic [WORD_W-1:0] rdata;
   logic              rdata_valid;
   logic              ready;
   logic              collision;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [WORD_W-1:0] prog_data;

   modport master (
      output CS, R_NW, addr, wdata, prog_we, prog_addr, prog_data,
      input  rdata, rdata_valid, ready, collision
   );

   modport slave (
      input  CS, R_NW, addr, wdata, prog_we, prog_addr, prog_data,
      output rdata, rdata_valid, ready, collision
   );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory answering CS/R_NW strobes, with optional wait states,
// a registered read port and a sticky collision flag.
module mem_responder #(
   parameter int unsigned WORD_W      = 8,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic            clock,
   input logic            reset,
   mem_responder_if.slave bus
);
   localparam int unsigned Depth = 2 ** ADDR_W;

   typedef enum logic [1:0] {StIdle, StWait, StAccess} state_e;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
   logic              cap_rnw_q, cap_rnw_d;
   logic [WORD_W-1:0] cap_wdata_q, cap_wdata_d;
   logic [WORD_W-1:0] rdata_q;
   logic              rdata_valid_q;
   logic              collision_q, collision_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [WORD_W-1:0] mem_wdata;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;

   logic [WORD_W-1:0] mem [Depth];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_addr_d  = cap_addr_q;
      cap_rnw_d   = cap_rnw_q;
      cap_wdata_d = cap_wdata_q;
      collision_d = collision_q;
      mem_we      = 1'b0;
      mem_waddr   = bus.prog_addr;
      mem_wdata   = bus.prog_data;
      rd_en       = 1'b0;
      rd_addr     = cap_addr_q;

      case (state_q)
         StIdle: begin
            if (bus.CS) begin
               cap_addr_d  = bus.addr;
               cap_rnw_d   = bus.R_NW;
               cap_wdata_d = bus.wdata;
               // CS wins over a simultaneous program write
               if (bus.prog_we) collision_d = 1'b1;
               if (WAIT_STATES == 0) begin
                  if (bus.R_NW) begin
                     rd_en   = 1'b1;
                     rd_addr = bus.addr;
                  end else begin
                     mem_we    = 1'b1;
                     mem_waddr = bus.addr;
                     mem_wdata = bus.wdata;
                  end
               end else begin
                  cnt_d   = 4'(WAIT_STATES - 1);
                  state_d = StWait;
               end
            end else if (bus.prog_we) begin
               mem_we = 1'b1;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StAccess;
            else               cnt_d   = cnt_q - 4'd1;
            if (bus.CS || bus.prog_we) collision_d = 1'b1;
         end
         StAccess: begin
            if (cap_rnw_q) begin
               rd_en = 1'b1;
            end else begin
               mem_we    = 1'b1;
               mem_waddr = cap_addr_q;
               mem_wdata = cap_wdata_q;
            end
            state_d = StIdle;
            if (bus.CS || bus.prog_we) collision_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         cnt_q         <= 4'd0;
         cap_addr_q    <= '0;
         cap_rnw_q     <= 1'b0;
         cap_wdata_q   <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         collision_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cap_addr_q    <= cap_addr_d;
         cap_rnw_q     <= cap_rnw_d;
         cap_wdata_q   <= cap_wdata_d;
         rdata_valid_q <= rd_en;
         collision_q   <= collision_d;
         if (rd_en) rdata_q <= mem[rd_addr];
      end
   end

   // Array is deliberately not reset; a write racing reset is discarded.
   always_ff @(posedge clock) begin
      if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
   end

   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;
   assign bus.ready       = (state_q == StIdle);
   assign bus.collision   = collision_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with 0, 2 and 3 wait states.
module tb_mem_responder;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic reset0, reset2, reset3;
   int   n_cmp = 0;
   int   n_bad = 0;

   mem_responder_if #(.WORD_W(8), .ADDR_W(5)) if0 ();
   mem_responder_if #(.WORD_W(8), .ADDR_W(5)) if2 ();
   mem_responder_if #(.WORD_W(8), .ADDR_W(5)) if3 ();

   mem_responder #(.WORD_W(8), .ADDR_W(5), .WAIT_STATES(0)) dut0 (
      .clock(clock), .reset(reset0), .bus(if0)
   );
   mem_responder #(.WORD_W(8), .ADDR_W(5), .WAIT_STATES(2)) dut2 (
      .clock(clock), .reset(reset2), .bus(if2)
   );
   mem_responder #(.WORD_W(8), .ADDR_W(5), .WAIT_STATES(3)) dut3 (
      .clock(clock), .reset(reset3), .bus(if3)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset0 = 1'b1; reset2 = 1'b1; reset3 = 1'b1;
      tick();
      n_cmp++; if (if0.rdata !== 8'h00) begin n_bad++;
         $display("FAIL rst_rdata0: got %h want 00", if0.rdata); end
      n_cmp++; if (if0.rdata_valid !== 1'b0) begin n_bad++;
         $display("FAIL rst_valid0: got %b want 0", if0.rdata_valid); end
      n_cmp++; if (if0.ready !== 1'b1) begin n_bad++;
         $display("FAIL rst_ready0: got %b want 1", if0.ready); end
      n_cmp++; if (if0.collision !== 1'b0) begin n_bad++;
         $display("FAIL rst_coll0: got %b want 0", if0.collision); end
      n_cmp++; if (if2.ready !== 1'b1) begin n_bad++;
         $display("FAIL rst_ready2: got %b want 1", if2.ready); end
      n_cmp++; if (if3.rdata !== 8'h00) begin n_bad++;
         $display("FAIL rst_rdata3: got %h want 00", if3.rdata); end
      reset0 = 1'b0; reset2 = 1'b0; reset3 = 1'b0;
      tick();
   endtask

   task automatic test_read_w0;
      if0.prog_we = 1'b1; if0.prog_addr = 5'd3; if0.prog_data = 8'h5A;
      tick();
      if0.prog_we = 1'b0;
      if0.CS = 1'b1; if0.R_NW = 1'b1; if0.addr = 5'd3;
      tick();
      if0.CS = 1'b0;
      n_cmp++; if (if0.rdata !== 8'h5A || if0.rdata_valid !== 1'b1) begin n_bad++;
         $display("FAIL w0_read: got %h/%b want 5a/1", if0.rdata, if0.rdata_valid); end
      tick();
      n_cmp++; if (if0.rdata_valid !== 1'b0 || if0.rdata !== 8'h5A) begin n_bad++;
         $display("FAIL w0_read_pulse: got %h/%b want 5a/0", if0.rdata, if0.rdata_valid); end
   endtask

   task automatic test_write_read;
      if0.CS = 1'b1; if0.R_NW = 1'b0; if0.addr = 5'd7; if0.wdata = 8'hC3;
      tick();
      n_cmp++; if (if0.rdata_valid !== 1'b0 || if0.rdata !== 8'h5A) begin n_bad++;
         $display("FAIL wr_no_pulse: got %h/%b want 5a/0", if0.rdata, if0.rdata_valid); end
      n_cmp++; if (if0.ready !== 1'b1) begin n_bad++;
         $display("FAIL wr_ready: got %b want 1", if0.ready); end
      if0.R_NW = 1'b1;
      tick();
      if0.CS = 1'b0;
      n_cmp++; if (if0.rdata !== 8'hC3 || if0.rdata_valid !== 1'b1) begin n_bad++;
         $display("FAIL wr_readback: got %h/%b want c3/1", if0.rdata, if0.rdata_valid); end
      tick();
   endtask

   task automatic test_prog_collision;
      n_cmp++; if (if0.collision !== 1'b0) begin n_bad++;
         $display("FAIL pc_pre_coll: got %b want 0", if0.collision); end
      if0.CS = 1'b1; if0.R_NW = 1'b0; if0.addr = 5'd4; if0.wdata = 8'h22;
      if0.prog_we = 1'b1; if0.prog_addr = 5'd4; if0.prog_data = 8'h99;
      tick();
      if0.CS = 1'b0; if0.prog_we = 1'b0;
      n_cmp++; if (if0.collision !== 1'b1) begin n_bad++;
         $display("FAIL pc_coll: got %b want 1", if0.collision); end
      if0.CS = 1'b1; if0.R_NW = 1'b1; if0.addr = 5'd4;
      tick();
      if0.CS = 1'b0;
      n_cmp++; if (if0.rdata !== 8'h22) begin n_bad++;
         $display("FAIL pc_mem4: got %h want 22", if0.rdata); end
      tick();
      n_cmp++; if (if0.collision !== 1'b1) begin n_bad++;
         $display("FAIL pc_sticky: got %b want 1", if0.collision); end
   endtask

   task automatic test_wait2;
      if2.prog_we = 1'b1; if2.prog_addr = 5'd0; if2.prog_data = 8'h11;
      tick();
      if2.prog_we = 1'b0;
      if2.CS = 1'b1; if2.R_NW = 1'b1; if2.addr = 5'd0;
      tick();
      if2.CS = 1'b0;
      n_cmp++; if (if2.ready !== 1'b0 || if2.rdata_valid !== 1'b0) begin n_bad++;
         $display("FAIL w2_c1: ready/valid %b/%b want 0/0", if2.ready, if2.rdata_valid); end
      tick();
      n_cmp++; if (if2.ready !== 1'b0 || if2.collision !== 1'b0) begin n_bad++;
         $display("FAIL w2_c2: ready/coll %b/%b want 0/0", if2.ready, if2.collision); end
      // stray write during WAIT must be ignored
      if2.CS = 1'b1; if2.R_NW = 1'b0; if2.addr = 5'd0; if2.wdata = 8'hEE;
      tick();
      if2.CS = 1'b0;
      n_cmp++; if (if2.ready !== 1'b0 || if2.collision !== 1'b1) begin n_bad++;
         $display("FAIL w2_c3: ready/coll %b/%b want 0/1", if2.ready, if2.collision); end
      tick();
      n_cmp++; if (if2.ready !== 1'b1 || if2.rdata_valid !== 1'b1 || if2.rdata !== 8'h11)
         begin n_bad++;
         $display("FAIL w2_c4: ready/valid/rdata %b/%b/%h want 1/1/11",
                  if2.ready, if2.rdata_valid, if2.rdata); end
      tick();
      n_cmp++; if (if2.rdata_valid !== 1'b0 || if2.rdata !== 8'h11) begin n_bad++;
         $display("FAIL w2_c5: valid/rdata %b/%h want 0/11", if2.rdata_valid, if2.rdata); end
      if2.CS = 1'b1; if2.R_NW = 1'b1; if2.addr = 5'd0;
      tick();
      if2.CS = 1'b0;
      tick(); tick(); tick();
      n_cmp++; if (if2.rdata_valid !== 1'b1 || if2.rdata !== 8'h11) begin n_bad++;
         $display("FAIL w2_reread: valid/rdata %b/%h want 1/11", if2.rdata_valid, if2.rdata); end
   endtask

   task automatic read3(input logic [4:0] a, output logic [7:0] d, output bit ok);
      if3.CS = 1'b1; if3.R_NW = 1'b1; if3.addr = a;
      tick();
      if3.CS = 1'b0;
      ok = 1'b0;
      d  = 8'h00;
      for (int k = 0; k < 10 && !ok; k++) begin
         if (if3.rdata_valid) begin
            ok = 1'b1;
            d  = if3.rdata;
         end else begin
            tick();
         end
      end
      tick();
   endtask

   task automatic test_reset_mid;
      logic [7:0] d;
      bit         ok;
      if3.prog_we = 1'b1; if3.prog_addr = 5'd9; if3.prog_data = 8'h01;
      tick();
      if3.prog_we = 1'b0;
      read3(5'd9, d, ok);
      n_cmp++; if (!ok || d !== 8'h01) begin n_bad++;
         $display("FAIL rm_preload: got %h ok=%0d want 01", d, ok); end
      if3.CS = 1'b1; if3.R_NW = 1'b0; if3.addr = 5'd9; if3.wdata = 8'h77;
      tick();
      if3.CS = 1'b0;
      n_cmp++; if (if3.ready !== 1'b0) begin n_bad++;
         $display("FAIL rm_busy: got %b want 0", if3.ready); end
      tick();
      reset3 = 1'b1;
      #2;
      n_cmp++; if (if3.ready !== 1'b1 || if3.rdata !== 8'h00 || if3.rdata_valid !== 1'b0)
         begin n_bad++;
         $display("FAIL rm_async: ready/rdata/valid %b/%h/%b want 1/00/0",
                  if3.ready, if3.rdata, if3.rdata_valid); end
      reset3 = 1'b0;
      tick();
      tick();
      read3(5'd9, d, ok);
      n_cmp++; if (!ok || d !== 8'h01) begin n_bad++;
         $display("FAIL rm_mem9: got %h ok=%0d want 01", d, ok); end
   endtask

   task automatic test_back_to_back_sweep;
      logic [7:0] exp_d;
      for (int i = 0; i < 32; i++) begin
         if0.prog_we = 1'b1; if0.prog_addr = 5'(i); if0.prog_data = 8'(i) ^ 8'hA5;
         tick();
      end
      if0.prog_we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if0.CS = 1'b1; if0.R_NW = 1'b1; if0.addr = 5'(i);
         tick();
         exp_d = 8'(i) ^ 8'hA5;
         n_cmp++; if (if0.rdata !== exp_d || if0.rdata_valid !== 1'b1) begin n_bad++;
            $display("FAIL sweep[%0d]: got %h/%b want %h/1",
                     i, if0.rdata, if0.rdata_valid, exp_d); end
      end
      if0.CS = 1'b0;
      tick();
   endtask

   initial begin
      if0.CS = 1'b0; if0.R_NW = 1'b0; if0.addr = '0; if0.wdata = '0;
      if0.prog_we = 1'b0; if0.prog_addr = '0; if0.prog_data = '0;
      if2.CS = 1'b0; if2.R_NW = 1'b0; if2.addr = '0; if2.wdata = '0;
      if2.prog_we = 1'b0; if2.prog_addr = '0; if2.prog_data = '0;
      if3.CS = 1'b0; if3.R_NW = 1'b0; if3.addr = '0; if3.wdata = '0;
      if3.prog_we = 1'b0; if3.prog_addr = '0; if3.prog_data = '0;
      test_reset();
      test_read_w0();
      test_write_read();
      test_prog_collision();
      test_wait2();
      test_reset_mid();
      test_back_to_back_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end
endmodule
